// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard port: bus offsets,
// scan-code prefixes, receiver states and edgeCapture bit positions.
package kbd_pkg;

  localparam logic [3:0] OFS_DATA = 4'h0;
  localparam logic [3:0] OFS_MB   = 4'h4;
  localparam logic [3:0] OFS_EDGE = 4'h8;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int EC_EDGE = 0;
  localparam int EC_ERR  = 1;
  localparam int EC_OVR  = 2;

  // Odd parity: data plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises the pins, samples on
// falling clock edges and checks parity/stop before presenting a byte.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  dbg_state
);

  // byte_valid is a one-cycle strobe with no ready: the consumer must take
  // rx_byte in the cycle byte_valid is high; rx_byte holds until the next one.

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic          timeout;
  logic [TW-1:0] tcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  rx_state_t     state, state_nxt;

  // Synchroniser flops idle high, matching an undriven PS/2 line.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall      = clk_s3 & ~clk_s2;
  assign timeout   = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset || fall || timeout || state == IDLE) tcnt <= '0;
    else                                           tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall && !timeout) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {dat_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_q <= dat_s2;
          STOP: begin
            if (parity_ok(shift_q, par_q) && dat_s2) begin
              rx_byte    <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// Memory-mapped PS/2 keyboard port: folds E0/F0 prefixes into key events
// and exposes data, makeBreak and edgeCapture registers to the processor.
module ps2_kbd_port
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        kbd_cs,
  input  logic [3:0]  addr,
  input  logic        W,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;
  rx_state_t   rx_state;

  logic [31:0] data_r;
  logic [31:0] mb_r;
  logic        edge_r, err_r, ovr_r;
  logic        ext_r, brk_r;
  logic        evt;
  logic        clr;
  logic [31:0] edge_cap;
  logic        unused_ok;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .dbg_state  (rx_state)
  );

  assign evt      = byte_valid && (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
  assign clr      = kbd_cs && W && (addr == OFS_EDGE);
  assign edge_cap = {29'b0, ovr_r, err_r, edge_r};
  assign unused_ok = &{1'b0, wdata[31:3], rx_state};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      mb_r   <= '0;
      ext_r  <= 1'b0;
      brk_r  <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_r <= 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_r <= 1'b1;
      end else begin
        data_r <= {23'b0, ext_r, rx_byte};
        mb_r   <= {31'b0, ~brk_r};
        ext_r  <= 1'b0;
        brk_r  <= 1'b0;
      end
    end
  end

  // Status bits: a new event or error beats a write-1-to-clear in the same
  // cycle, and an event racing a clear of edge does not count as an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_r <= 1'b0;
      err_r  <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      if (evt)                        edge_r <= 1'b1;
      else if (clr && wdata[EC_EDGE]) edge_r <= 1'b0;

      if (frame_err)                  err_r <= 1'b1;
      else if (clr && wdata[EC_ERR])  err_r <= 1'b0;

      if (evt && edge_r && !(clr && wdata[EC_EDGE])) ovr_r <= 1'b1;
      else if (clr && wdata[EC_OVR])                 ovr_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (kbd_cs && !W) begin
      case (addr)
        OFS_DATA: rdata <= data_r;
        OFS_MB:   rdata <= mb_r;
        OFS_EDGE: rdata <= edge_cap;
        default:  rdata <= '0;
      endcase
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Directed bench for ps2_kbd_port: drives PS/2 frames and bus cycles,
// scoreboards expected register contents and prints one summary line.
module tb_ps2_kbd_port;

  localparam int TO = 12500;
  localparam int HB = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_dat;
  logic        kbd_cs;
  logic [3:0]  addr;
  logic        W;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ps2_kbd_port #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .kbd_cs  (kbd_cs),
    .addr    (addr),
    .W       (W),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    kbd_cs = 1'b1; W = 1'b0; addr = a;
    @(posedge clk);
    #1 v = rdata;
    kbd_cs = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    kbd_cs = 1'b1; W = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    kbd_cs = 1'b0; W = 1'b0; wdata = '0;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Start bit plus the first n data bits, then the line is left idle.
  task automatic send_bits(input int n, input logic [7:0] b);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  // clr_commit lands a W1C of edge on exactly the register-update cycle:
  // three cycles to the edge strobe, one more for the event commit.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input logic clr_commit);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    @(negedge clk);
    ps2_dat = bad_stop ? 1'b0 : 1'b1;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b0;
    if (clr_commit) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      kbd_cs = 1'b1; W = 1'b1; addr = 4'h8; wdata = 32'h1;
      @(posedge clk);
      @(negedge clk);
      kbd_cs = 1'b0; W = 1'b0; wdata = '0;
      repeat (HB - 2) @(negedge clk);
    end else begin
      repeat (HB) @(negedge clk);
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_regs(input string tag, input logic [31:0] d,
                             input logic [31:0] m, input logic [31:0] e);
    logic [31:0] v;
    exp_q.push_back(d);
    exp_q.push_back(m);
    exp_q.push_back(e);
    rd(4'h0, v); check({tag, ".data"}, v, exp_q.pop_front());
    rd(4'h4, v); check({tag, ".mb"},   v, exp_q.pop_front());
    rd(4'h8, v); check({tag, ".edge"}, v, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    kbd_cs = 1'b0; W = 1'b0; addr = '0; wdata = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    expect_regs("reset", 32'h0, 32'h0, 32'h0);

    // Plain make code, then write-1-to-clear.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("make_1c", 32'h01C, 32'h1, 32'h1);
    wr(4'h8, 32'h1);
    expect_regs("clr_edge", 32'h01C, 32'h1, 32'h0);

    // Break prefix alone changes nothing; completed break code does.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    expect_regs("after_f0", 32'h01C, 32'h1, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("break_1c", 32'h01C, 32'h0, 32'h1);
    wr(4'h8, 32'h1);

    // Extended break.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    expect_regs("ext_brk_75", 32'h175, 32'h0, 32'h1);
    wr(4'h8, 32'h1);

    // Corrupt frames set err only.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    expect_regs("bad_par", 32'h175, 32'h0, 32'h2);
    wr(4'h8, 32'h2);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    expect_regs("bad_stop", 32'h175, 32'h0, 32'h2);
    wr(4'h8, 32'h2);

    // Prefixes were consumed by the 0x75 event.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("flags_clr", 32'h01C, 32'h1, 32'h1);
    wr(4'h8, 32'h1);

    // Abandoned frame times out without err.
    send_bits(4, 8'h0F);
    repeat (TO + 100) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    expect_regs("after_to", 32'h029, 32'h1, 32'h1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("overrun", 32'h01C, 32'h1, 32'h5);

    rd(4'h2, v);
    check("odd_offset", v, 32'h0);
    wr(4'h0, 32'h7);
    rd(4'h8, v);
    check("wr_ignored", v, 32'h5);
    wr(4'h8, 32'h7);
    expect_regs("clr_all", 32'h01C, 32'h1, 32'h0);

    // Event commit racing a clear of an already-set edge.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("pre_race", 32'h01C, 32'h1, 32'h1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b1);
    expect_regs("race", 32'h075, 32'h1, 32'h1);

    // Reset mid-frame drops registers, prefixes and the partial byte.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_bits(3, 8'h05);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_regs("mid_rst", 32'h0, 32'h0, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_regs("post_rst", 32'h01C, 32'h1, 32'h1);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
